// File: rtl/mat_tile_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mat_tile_engine : weight-tile load, vector stream and credit-limited       |
// |                   result write-back sequencer for the systolic unit.       |
// | Optional: MAT_TILE_PERF_EN adds perf_cycles / perf_stalls counters.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mat_tile_engine #(
  parameter int WIDTH      = 16,
  parameter int ELEM_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int VEC_CNT_W  = 16,
  parameter int UNIT_LAT   = WIDTH * 2,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic [ADDR_W-1:0]        w_base,
  input  logic [ADDR_W-1:0]        in_base,
  input  logic [ADDR_W-1:0]        out_base,
  input  logic [VEC_CNT_W-1:0]     num_vec,
  output logic                     busy,
  output logic                     done,
  output logic                     rd_req,
  output logic [ADDR_W-1:0]        rd_addr,
  input  logic [WIDTH*ELEM_W-1:0]  rd_data,
  output logic                     wr_en,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic [WIDTH*ELEM_W-1:0]  wr_data,
  input  logic                     wr_ready,
  output logic                     unit_set_weight,
  output logic [$clog2(WIDTH)-1:0] unit_set_weight_row,
  output logic                     unit_in_valid,
  output logic [WIDTH*ELEM_W-1:0]  unit_data_in,
  input  logic [WIDTH*ELEM_W-1:0]  unit_data_out
`ifdef MAT_TILE_PERF_EN
  ,
  output logic [31:0]              perf_cycles,
  output logic [31:0]              perf_stalls
`endif
);

  localparam int DATA_W = WIDTH * ELEM_W;
  localparam int ROW_W  = $clog2(WIDTH);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD_W = 2'd1,
    S_STREAM = 2'd2,
    S_DRAIN  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [ADDR_W-1:0]    w_base_q, w_base_d;
  logic [ADDR_W-1:0]    in_base_q, in_base_d;
  logic [ADDR_W-1:0]    out_addr_q, out_addr_d;
  logic [VEC_CNT_W-1:0] num_vec_q, num_vec_d;
  logic [VEC_CNT_W-1:0] issued_q, issued_d;
  logic [ROW_W-1:0]     row_q, row_d;
  logic                 rd_pend_q, rd_pend_d;
  logic                 rd_wt_q, rd_wt_d;
  logic [ROW_W-1:0]     rd_row_q, rd_row_d;
  logic [UNIT_LAT-1:0]  valid_sr_q, valid_sr_d;
  logic [CNT_W-1:0]     in_flight_q, in_flight_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0]    fifo_mem_q [FIFO_DEPTH];

  logic                 load_rd;
  logic                 issue;
  logic                 credit_ok;
  logic                 tap;
  logic                 pop;
  logic [CNT_W:0]       outstanding;

  // Credit counts every vector issued but not yet written, so the FIFO can never overflow.
  always_comb begin
    outstanding = {1'b0, in_flight_q} + {1'b0, count_q};
    credit_ok   = outstanding < (CNT_W + 1)'(FIFO_DEPTH);
    tap         = valid_sr_q[UNIT_LAT-1];
    wr_en       = count_q != '0;
    pop         = wr_en && wr_ready;
  end

  always_comb begin
    state_d    = state_q;
    w_base_d   = w_base_q;
    in_base_d  = in_base_q;
    out_addr_d = pop ? out_addr_q + 1'b1 : out_addr_q;
    num_vec_d  = num_vec_q;
    issued_d   = issued_q;
    row_d      = row_q;
    done       = 1'b0;
    load_rd    = 1'b0;
    issue      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          w_base_d   = w_base;
          in_base_d  = in_base;
          out_addr_d = out_base;
          num_vec_d  = num_vec;
          issued_d   = '0;
          row_d      = '0;
          state_d    = S_LOAD_W;
        end
      end
      S_LOAD_W: begin
        load_rd = 1'b1;
        row_d   = row_q + 1'b1;
        if (row_q == ROW_W'(WIDTH - 1)) begin
          state_d = S_STREAM;
        end
      end
      S_STREAM: begin
        if (issued_q == num_vec_q) begin
          state_d = S_DRAIN;
        end else if (credit_ok) begin
          issue    = 1'b1;
          issued_d = issued_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (!rd_pend_q && (in_flight_q == '0) && (count_q == '0)) begin
          done    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy    = state_q != S_IDLE;
    rd_req  = load_rd | issue;
    rd_addr = '0;
    if (load_rd) begin
      rd_addr = w_base_q + ADDR_W'(row_q);
    end else if (issue) begin
      rd_addr = in_base_q + ADDR_W'(issued_q);
    end

    // Read data returns one cycle later and goes straight to the unit.
    rd_pend_d           = rd_req;
    rd_wt_d             = load_rd;
    rd_row_d            = row_q;
    unit_set_weight     = rd_pend_q & rd_wt_q;
    unit_in_valid       = rd_pend_q & ~rd_wt_q;
    unit_set_weight_row = rd_row_q;
    unit_data_in        = rd_pend_q ? rd_data : '0;

    valid_sr_d  = {valid_sr_q[UNIT_LAT-2:0], unit_in_valid};
    in_flight_d = in_flight_q + CNT_W'(issue) - CNT_W'(tap);
    count_d     = count_q + CNT_W'(tap) - CNT_W'(pop);
    wr_ptr_d    = tap ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d    = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;

    wr_addr = wr_en ? out_addr_q : '0;
    wr_data = wr_en ? fifo_mem_q[rd_ptr_q] : '0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      w_base_q    <= '0;
      in_base_q   <= '0;
      out_addr_q  <= '0;
      num_vec_q   <= '0;
      issued_q    <= '0;
      row_q       <= '0;
      rd_pend_q   <= 1'b0;
      rd_wt_q     <= 1'b0;
      rd_row_q    <= '0;
      valid_sr_q  <= '0;
      in_flight_q <= '0;
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      w_base_q    <= w_base_d;
      in_base_q   <= in_base_d;
      out_addr_q  <= out_addr_d;
      num_vec_q   <= num_vec_d;
      issued_q    <= issued_d;
      row_q       <= row_d;
      rd_pend_q   <= rd_pend_d;
      rd_wt_q     <= rd_wt_d;
      rd_row_q    <= rd_row_d;
      valid_sr_q  <= valid_sr_d;
      in_flight_q <= in_flight_d;
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clock) begin
    if (tap) begin
      fifo_mem_q[wr_ptr_q] <= unit_data_out;
    end
  end

`ifdef MAT_TILE_PERF_EN
  logic [31:0] perf_cycles_q, perf_cycles_d;
  logic [31:0] perf_stalls_q, perf_stalls_d;
  logic [32:0] cyc_sum;
  logic [32:0] stall_sum;
  logic        stall_credit;
  logic        stall_wr;

  always_comb begin
    stall_credit  = (state_q == S_STREAM) && (issued_q != num_vec_q) && !credit_ok;
    stall_wr      = wr_en && !wr_ready;
    cyc_sum       = {1'b0, perf_cycles_q} + 33'(busy);
    stall_sum     = {1'b0, perf_stalls_q} + 33'(stall_credit) + 33'(stall_wr);
    perf_cycles_d = cyc_sum[32] ? '1 : cyc_sum[31:0];
    perf_stalls_d = stall_sum[32] ? '1 : stall_sum[31:0];
    if ((state_q == S_IDLE) && start) begin
      perf_cycles_d = '0;
      perf_stalls_d = '0;
    end
    perf_cycles = perf_cycles_q;
    perf_stalls = perf_stalls_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      perf_cycles_q <= '0;
      perf_stalls_q <= '0;
    end else begin
      perf_cycles_q <= perf_cycles_d;
      perf_stalls_q <= perf_stalls_d;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mat_tile_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mat_tile_engine : scoreboard bench with memory and systolic unit models.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_mat_tile_engine;
  localparam int WIDTH      = 16;
  localparam int ELEM_W     = 32;
  localparam int ADDR_W     = 32;
  localparam int VEC_CNT_W  = 16;
  localparam int UNIT_LAT   = WIDTH * 2;
  localparam int FIFO_DEPTH = 8;
  localparam int DATA_W     = WIDTH * ELEM_W;
  localparam int ROW_W      = $clog2(WIDTH);

  logic                 clock = 1'b0;
  logic                 reset = 1'b0;
  logic                 start = 1'b0;
  logic [ADDR_W-1:0]    w_base = '0;
  logic [ADDR_W-1:0]    in_base = '0;
  logic [ADDR_W-1:0]    out_base = '0;
  logic [VEC_CNT_W-1:0] num_vec = '0;
  logic                 wr_ready = 1'b1;
  logic                 busy, done, rd_req, wr_en, unit_set_weight, unit_in_valid;
  logic [ADDR_W-1:0]    rd_addr, wr_addr;
  logic [DATA_W-1:0]    rd_data, wr_data, unit_data_in, unit_data_out;
  logic [ROW_W-1:0]     unit_set_weight_row;
`ifdef MAT_TILE_PERF_EN
  logic [31:0]          perf_cycles, perf_stalls;
`endif

  mat_tile_engine #(
    .WIDTH(WIDTH), .ELEM_W(ELEM_W), .ADDR_W(ADDR_W), .VEC_CNT_W(VEC_CNT_W),
    .UNIT_LAT(UNIT_LAT), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .w_base(w_base), .in_base(in_base),
    .out_base(out_base), .num_vec(num_vec), .busy(busy), .done(done), .rd_req(rd_req),
    .rd_addr(rd_addr), .rd_data(rd_data), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_ready(wr_ready), .unit_set_weight(unit_set_weight),
    .unit_set_weight_row(unit_set_weight_row), .unit_in_valid(unit_in_valid),
    .unit_data_in(unit_data_in), .unit_data_out(unit_data_out)
`ifdef MAT_TILE_PERF_EN
    , .perf_cycles(perf_cycles), .perf_stalls(perf_stalls)
`endif
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int rd_cnt = 0, exp_row = 0, inputs_issued = 0, writes_done = 0, busy_cycles = 0;
  int done_seen = 0, start_cyc = 0, last_sw_cyc = 0, last_hs_cyc = 0;
  logic [ADDR_W-1:0] cur_w_base = '0;

  logic [ADDR_W-1:0] exp_rd_q[$];
  logic [ADDR_W-1:0] exp_wa_q[$];
  logic [DATA_W-1:0] exp_wd_q[$];
  int                exp_done_q[$];

  task automatic chk(input string name, input logic ok, input longint act, input longint exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_eq(input string name, input longint act, input longint exp);
    chk(name, act == exp, act, exp);
  endtask

  task automatic chk_data(input string name, input logic [DATA_W-1:0] act,
                          input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] v;
    for (int l = 0; l < WIDTH; l++) begin
      v[l*ELEM_W +: ELEM_W] = (a * 32'h9E37_79B1) + (32'(l) * 32'h0100_0193);
    end
    return v;
  endfunction

  function automatic logic [DATA_W-1:0] identity(input int r);
    logic [DATA_W-1:0] v;
    v = '0;
    v[r*ELEM_W +: ELEM_W] = 32'd1;
    return v;
  endfunction

  function automatic logic [DATA_W-1:0] mem_rd(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] off;
    off = a - cur_w_base;
    if (off < 32'(WIDTH)) return identity(int'(off));
    return pattern(a);
  endfunction

  // Memory: fixed one-cycle read latency.
  always @(posedge clock) begin
    if (rd_req) rd_data <= mem_rd(rd_addr);
    else        rd_data <= pattern(32'hDEAD_BEEF);
  end

  // Systolic unit: out[j] = sum_r W[r][j] * x[r], delivered UNIT_LAT cycles later.
  logic [ELEM_W-1:0] wts  [WIDTH][WIDTH];
  logic [DATA_W-1:0] pipe [UNIT_LAT];

  function automatic logic [DATA_W-1:0] matvec(input logic [DATA_W-1:0] x);
    logic [DATA_W-1:0] y;
    logic [ELEM_W-1:0] acc;
    for (int j = 0; j < WIDTH; j++) begin
      acc = '0;
      for (int r = 0; r < WIDTH; r++) acc = acc + wts[r][j] * x[r*ELEM_W +: ELEM_W];
      y[j*ELEM_W +: ELEM_W] = acc;
    end
    return y;
  endfunction

  always @(posedge clock) begin
    if (unit_set_weight) begin
      for (int j = 0; j < WIDTH; j++)
        wts[unit_set_weight_row][j] <= unit_data_in[j*ELEM_W +: ELEM_W];
    end
    pipe[0] <= unit_in_valid ? matvec(unit_data_in) : '0;
    for (int i = 1; i < UNIT_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign unit_data_out = pipe[UNIT_LAT-1];

  // Monitor: pops expectations as the DUT presents reads, weight rows, writes and done.
  initial begin
    logic [ADDR_W-1:0] ea;
    logic [DATA_W-1:0] ed;
    int                n;
    forever begin
      @(negedge clock);
      cyc++;
      if (reset) begin
        if (start && !busy) start_cyc = cyc;
        if (busy) busy_cycles++;
        if (rd_req) begin
          rd_cnt++;
          if (exp_rd_q.size() == 0) chk("rd_unexpected", 1'b0, rd_addr, 0);
          else begin
            ea = exp_rd_q.pop_front();
            chk_eq("rd_addr", rd_addr, ea);
          end
          if (rd_cnt > WIDTH) begin
            inputs_issued++;
            chk("credit_limit", (inputs_issued - writes_done) <= FIFO_DEPTH,
                inputs_issued - writes_done, FIFO_DEPTH);
          end
        end
        if (unit_set_weight) begin
          chk_eq("wt_row", unit_set_weight_row, exp_row);
          chk_data("wt_data", unit_data_in, identity(exp_row % WIDTH));
          exp_row++;
          last_sw_cyc = cyc;
        end
        if (wr_en && wr_ready) begin
          if (exp_wa_q.size() == 0) chk("wr_unexpected", 1'b0, wr_addr, 0);
          else begin
            ea = exp_wa_q.pop_front();
            ed = exp_wd_q.pop_front();
            chk_eq("wr_addr", wr_addr, ea);
            chk_data("wr_data", wr_data, ed);
          end
          writes_done++;
          last_hs_cyc = cyc;
        end
        if (done) begin
          done_seen++;
          chk("busy_at_done", busy, busy, 1);
          if (exp_done_q.size() == 0) chk("done_unexpected", 1'b0, 1, 0);
          else begin
            n = exp_done_q.pop_front();
            if (n > 0) chk_eq("done_after_last_wr", cyc - last_hs_cyc, 1);
            chk_eq("wr_left_at_done", exp_wa_q.size(), 0);
          end
        end
      end
    end
  end

  task automatic launch(input logic [ADDR_W-1:0] w, input logic [ADDR_W-1:0] in_b,
                        input logic [ADDR_W-1:0] out_b, input int n);
    cur_w_base = w;
    for (int r = 0; r < WIDTH; r++) exp_rd_q.push_back(w + 32'(r));
    for (int i = 0; i < n; i++) begin
      exp_rd_q.push_back(in_b + 32'(i));
      exp_wa_q.push_back(out_b + 32'(i));
      exp_wd_q.push_back(pattern(in_b + 32'(i)));
    end
    exp_done_q.push_back(n);
    rd_cnt = 0; exp_row = 0; inputs_issued = 0; writes_done = 0; busy_cycles = 0;
    w_base = w; in_base = in_b; out_base = out_b; num_vec = VEC_CNT_W'(n);
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    w_base = 32'h5A5A_0000; in_base = ~in_b; out_base = ~out_b; num_vec = '1;
    chk("busy_after_start", busy, busy, 1);
  endtask

  task automatic wait_done(input int budget);
    int d0;
    int k;
    d0 = done_seen;
    k = 0;
    while (done_seen == d0 && k < budget) begin
      @(posedge clock); #1;
      k++;
    end
    chk("done_timeout", done_seen != d0, k, budget);
    repeat (2) @(posedge clock);
    #1;
  endtask

  initial begin
    int k;
    int d0;
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk_eq("rst_busy", busy, 0);
    chk_eq("rst_done", done, 0);
    chk_eq("rst_rd_req", rd_req, 0);
    chk_eq("rst_wr_en", wr_en, 0);
    chk_eq("rst_set_weight", unit_set_weight, 0);
    chk_eq("rst_in_valid", unit_in_valid, 0);
    chk_eq("rst_rd_addr", rd_addr, 0);
    chk_eq("rst_wr_addr", wr_addr, 0);
    chk_data("rst_unit_data_in", unit_data_in, '0);
    reset = 1'b1;
    @(posedge clock); #1;

    // Zero-vector job: weights only.
    launch(32'h0000_0100, 32'h0000_4000, 32'h0000_8000, 0);
    wait_done(100);
    chk_eq("t2_reads", rd_cnt, WIDTH);
    chk_eq("t2_rows", exp_row, WIDTH);
    chk_eq("t2_writes", writes_done, 0);
    chk_eq("t2_last_row_latency", last_sw_cyc - start_cyc, WIDTH + 1);

    // Four vectors, no back-pressure.
    launch(32'h0000_0200, 32'h0000_1000, 32'h0000_3000, 4);
    wait_done(300);
    chk_eq("t3_writes", writes_done, 4);

    // Output address wrap.
    launch(32'h0000_0600, 32'h0000_2000, 32'hFFFF_FFFE, 4);
    wait_done(300);
    chk_eq("t5_writes", writes_done, 4);

    // Back-pressure: hold wr_ready low, try a start while busy.
    wr_ready = 1'b0;
    launch(32'h0000_0300, 32'h0000_5000, 32'h0000_7000, 20);
    k = 0;
    while (!wr_en && k < 300) begin
      @(posedge clock); #1;
      k++;
    end
    chk("t4_wr_en_seen", wr_en, k, 300);
    for (int c = 0; c < 50; c++) begin
      if (c == 10) begin
        start = 1'b1; w_base = 32'hAAAA_0000; in_base = 32'hBBBB_0000;
        out_base = 32'hCCCC_0000; num_vec = 16'd3;
      end
      if (c == 11) start = 1'b0;
      @(posedge clock); #1;
    end
    chk_eq("t4_outstanding", inputs_issued - writes_done, FIFO_DEPTH);
    chk_eq("t4_writes_stalled", writes_done, 0);
    wr_ready = 1'b1;
    wait_done(2000);
    chk_eq("t4_writes", writes_done, 20);
    chk_eq("t4_inputs", inputs_issued, 20);
`ifdef MAT_TILE_PERF_EN
    repeat (3) @(posedge clock);
    #1;
    chk("t6_perf_stalls", perf_stalls >= 50, perf_stalls, 50);
    chk_eq("t6_perf_cycles", perf_cycles, busy_cycles);
`endif

    // Mid-stream reset abandons the job.
    launch(32'h0000_0300, 32'h0000_5000, 32'h0000_7000, 20);
    repeat (25) @(posedge clock);
    #1;
    chk_eq("t1_busy_before_rst", busy, 1);
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    exp_rd_q.delete(); exp_wa_q.delete(); exp_wd_q.delete(); exp_done_q.delete();
    d0 = done_seen;
    reset = 1'b1;
    #1;
    chk_eq("t1_busy", busy, 0);
    chk_eq("t1_rd_req", rd_req, 0);
    chk_eq("t1_wr_en", wr_en, 0);
    repeat (60) @(posedge clock);
    #1;
    chk_eq("t1_no_done", done_seen, d0);
    chk_eq("t1_still_idle", busy, 0);

    // Fresh job after the abandoned one.
    launch(32'h0000_0700, 32'h0000_9000, 32'h0000_A000, 2);
    wait_done(300);
    chk_eq("post_rst_writes", writes_done, 2);

    chk_eq("rd_queue_empty", exp_rd_q.size(), 0);
    chk_eq("wr_queue_empty", exp_wa_q.size(), 0);
    chk_eq("done_queue_empty", exp_done_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
